cic_decim_comb: RTL

CIC_DECIM_COMB -- requirements
Module: cic_decim_comb

---
 rtl/cic_decim_comb_pkg.sv | 28 ++
 rtl/cic_decim_comb_stage.sv | 43 ++++
 rtl/cic_decim_comb.sv | 100 ++++++++++
 3 files changed

// File: rtl/cic_decim_comb_pkg.sv
// Shared CIC constants (widths, stage count, rounding shift) and the output rounding helper.
// The helper is used by cic_decim_comb when CIC_ROUND_OUT_EN is defined.
package cic_decim_comb_pkg;

  localparam int unsigned CIC_W      = 17;
  localparam int unsigned CIC_N      = 3;
  localparam int unsigned CIC_OUT_W  = 10;
  localparam int unsigned CIC_RND_SH = 7;

  // (x + 2^(SH-1)) >>> SH, clamped to the signed CIC_OUT_W range; one extra bit avoids add overflow
  function automatic logic [CIC_OUT_W-1:0] cic_round(input logic [CIC_W-1:0] x);
    logic signed [CIC_W:0] sum;
    logic signed [CIC_W:0] shf;
    logic signed [CIC_W:0] max_v;
    logic signed [CIC_W:0] min_v;
    max_v = $signed((CIC_W+1)'((1 << (CIC_OUT_W-1)) - 1));
    min_v = -$signed((CIC_W+1)'(1 << (CIC_OUT_W-1)));
    sum   = $signed({x[CIC_W-1], x}) + $signed((CIC_W+1)'(1 << (CIC_RND_SH-1)));
    shf   = sum >>> CIC_RND_SH;
    if (shf > max_v) begin
      shf = max_v;
    end else if (shf < min_v) begin
      shf = min_v;
    end
    return shf[CIC_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/cic_decim_comb_stage.sv
// One registered comb stage: out = in - previous in (M=1), modulo 2^CIC_W.
// The delay register only advances on valid input samples.
module cic_comb_stage
  import cic_decim_comb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CIC_W-1:0] in_data,
  input  logic             in_valid,
  output logic [CIC_W-1:0] out_data,
  output logic             out_valid
);

  logic [CIC_W-1:0] dly_q, dly_d;
  logic [CIC_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    dly_d   = dly_q;
    data_d  = data_q;
    valid_d = in_valid;
    if (in_valid) begin
      data_d = in_data - dly_q;
      dly_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dly_q   <= dly_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/cic_decim_comb.sv
// CIC decimator comb section: decimate-by-DECIM_R capture followed by CIC_N registered comb stages.
// Define CIC_ROUND_OUT_EN to add the rounded, saturated Yout port.
module cic_decim_comb
  import cic_decim_comb_pkg::*;
#(
  parameter int unsigned DECIM_R = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CIC_W-1:0]     Intin,
  input  logic                 in_valid,
  output logic [CIC_W-1:0]     Combout,
  output logic                 out_valid
`ifdef CIC_ROUND_OUT_EN
  ,output logic [CIC_OUT_W-1:0] Yout
`endif
);

  localparam int unsigned CNT_W = (DECIM_R > 1) ? $clog2(DECIM_R) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CIC_W-1:0] s0_data_q, s0_data_d;
  logic             s0_valid_q, s0_valid_d;
  logic             strobe_c;

  logic [CIC_N:0][CIC_W-1:0] c_data;
  logic [CIC_N:0]            c_valid;

  assign strobe_c = in_valid && (cnt_q == CNT_W'(DECIM_R - 1));

  // Decimation counter and stage-0 capture
  always_comb begin
    cnt_d      = cnt_q;
    s0_data_d  = s0_data_q;
    s0_valid_d = strobe_c;
    if (in_valid) begin
      cnt_d = strobe_c ? '0 : cnt_q + CNT_W'(1);
    end
    if (strobe_c) begin
      s0_data_d = Intin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      s0_data_q  <= '0;
      s0_valid_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      s0_data_q  <= s0_data_d;
      s0_valid_q <= s0_valid_d;
    end
  end

  assign c_data[0]  = s0_data_q;
  assign c_valid[0] = s0_valid_q;

  for (genvar k = 0; k < CIC_N; k++) begin : g_comb
    cic_comb_stage u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_data   (c_data[k]),
      .in_valid  (c_valid[k]),
      .out_data  (c_data[k+1]),
      .out_valid (c_valid[k+1])
    );
  end

  assign Combout   = c_data[CIC_N];
  assign out_valid = c_valid[CIC_N];

`ifdef CIC_ROUND_OUT_EN
  // Mirror of the last stage's delay so Yout lands in the same cycle as Combout
  logic [CIC_W-1:0]     ydly_q, ydly_d;
  logic [CIC_OUT_W-1:0] yout_q, yout_d;

  always_comb begin
    ydly_d = ydly_q;
    yout_d = yout_q;
    if (c_valid[CIC_N-1]) begin
      ydly_d = c_data[CIC_N-1];
      yout_d = cic_round(c_data[CIC_N-1] - ydly_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ydly_q <= '0;
      yout_q <= '0;
    end else begin
      ydly_q <= ydly_d;
      yout_q <= yout_d;
    end
  end

  assign Yout = yout_q;
`endif

endmodule
